// File: rtl/aes_apb_mc_slave_if.sv
// APB bus bundle for the multi-channel AES slave front-end.
//   master modport: drives paddr/pwdata/pprot/psel/penable/pwrite/pstrb and
//                   receives pready/pslverr/prdata.
//   slave modport : the mirror image, used by aes_apb_mc_slave.
interface aes_apb_mc_slave_if #(
  parameter int APB_ADDR_WIDTH   = 12,
  parameter int APB_DATA_WIDTH   = 32,
  parameter int APB_STROBE_WIDTH = APB_DATA_WIDTH / 8
);
  logic [APB_ADDR_WIDTH-1:0]   paddr;
  logic [APB_DATA_WIDTH-1:0]   pwdata;
  logic [2:0]                  pprot;
  logic                        psel;
  logic                        penable;
  logic                        pwrite;
  logic [APB_STROBE_WIDTH-1:0] pstrb;
  logic                        pready;
  logic                        pslverr;
  logic [APB_DATA_WIDTH-1:0]   prdata;

  modport master (
    output paddr, pwdata, pprot, psel, penable, pwrite, pstrb,
    input  pready, pslverr, prdata
  );

  modport slave (
    input  paddr, pwdata, pprot, psel, penable, pwrite, pstrb,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/aes_apb_mc_slave.sv
// Multi-channel APB slave front-end for NUM_CH independent AES cores.
// Per channel it holds KEY and DIN blocks, a START/BUSY/DONE handshake and
// the captured DOUT block, with programmable wait states, byte strobes and
// PSLVERR signalling.
//
// Ports:
//   pclk, preset     clock, synchronous active-high reset
//   apb              APB slave bus (aes_apb_mc_slave_if.slave)
//   core_start       one-cycle start pulse per channel
//   core_key/din     per-channel key / plaintext, channel c at [c*BLOCK_WIDTH +: BLOCK_WIDTH]
//   core_dout        per-channel result, same packing
//   core_done        one-cycle completion pulse per channel
//   irq              per-channel DONE & IRQ_EN, registered (only with AES_APB_IRQ_EN)
//
// Channel window (paddr[11:8] = channel, paddr[7:0] = byte offset):
//   0x00 CTRL (bit0 START pulse, bit1 IRQ_EN when AES_APB_IRQ_EN is defined)
//   0x04 STATUS (bit0 BUSY, bit1 DONE write-1-clear)
//   0x10 KEY, 0x30 DIN, 0x50 DOUT (read-only); word k at base + 4k, word 0 = LSBs
//
// Optional feature macro: AES_APB_IRQ_EN.
module aes_apb_mc_slave #(
  parameter int APB_ADDR_WIDTH   = 12,
  parameter int APB_DATA_WIDTH   = 32,
  parameter int APB_STROBE_WIDTH = APB_DATA_WIDTH / 8,
  parameter int NUM_CH           = 2,
  parameter int BLOCK_WIDTH      = 128,
  parameter int WAIT_STATES      = 1
) (
  input  logic                          pclk,
  input  logic                          preset,
  aes_apb_mc_slave_if.slave             apb,
  output logic [NUM_CH-1:0]             core_start,
  output logic [NUM_CH*BLOCK_WIDTH-1:0] core_key,
  output logic [NUM_CH*BLOCK_WIDTH-1:0] core_din,
  input  logic [NUM_CH*BLOCK_WIDTH-1:0] core_dout,
  input  logic [NUM_CH-1:0]             core_done
`ifdef AES_APB_IRQ_EN
  ,
  output logic [NUM_CH-1:0]             irq
`endif
);
  localparam int DW    = APB_DATA_WIDTH;
  localparam int SB    = APB_STROBE_WIDTH;
  localparam int W     = BLOCK_WIDTH / APB_DATA_WIDTH;
  localparam int LSB_W = $clog2(SB);

  localparam logic [7:0] CTRL_OFF  = 8'h00;
  localparam logic [7:0] STAT_OFF  = 8'h04;
  localparam logic [7:0] KEY_BASE  = 8'h10;
  localparam logic [7:0] DIN_BASE  = 8'h30;
  localparam logic [7:0] DOUT_BASE = 8'h50;
  localparam logic [7:0] BLK_SPAN  = 8'(W * SB);

  typedef logic [DW-1:0] word_t;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [4:0]        cnt_inc;
  logic              pready_q;

  word_t             key_q  [NUM_CH][W];
  word_t             din_q  [NUM_CH][W];
  word_t             dout_q [NUM_CH][W];
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] start_q;
`ifdef AES_APB_IRQ_EN
  logic [NUM_CH-1:0] irqen_q;
  logic [NUM_CH-1:0] irq_q;
`endif

  logic [3:0] ch;
  logic [7:0] off;
  logic [7:0] kidx, didx, oidx;
  logic       ch_ok, aligned, mapped;
  logic       is_ctrl, is_stat, is_key, is_din, is_dout;
  logic       busy_sel, start_req, err, xfer, commit;
  word_t      rdata;
  logic       unused_pprot;

  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input logic [SB-1:0] strb);
    word_t r;
    r = old_w;
    for (int b = 0; b < SB; b++)
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  assign unused_pprot = ^apb.pprot;
  assign cnt_inc      = {1'b0, cnt} + 5'd1;

  // The state tracks the bus phase of the current cycle: IDLE/SETUP both accept
  // a setup phase and move straight to ACCESS so that the first ACCESS cycle of
  // the FSM coincides with the first bus access cycle. SETUP is the
  // back-to-back landing state after a completed transfer with psel still high.
  // pready_q is precomputed one cycle ahead so it is high exactly in the
  // access cycle whose index equals WAIT_STATES.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      cnt      <= '0;
      pready_q <= 1'b0;
    end else begin
      case (state)
        IDLE, SETUP: begin
          cnt <= '0;
          if (apb.psel && !apb.penable) begin
            state    <= ACCESS;
            pready_q <= (WAIT_STATES == 0);
          end else begin
            state    <= IDLE;
            pready_q <= 1'b0;
          end
        end
        ACCESS: begin
          if (!apb.psel) begin
            state    <= IDLE;
            cnt      <= '0;
            pready_q <= 1'b0;
          end else if (pready_q) begin
            state    <= SETUP;
            cnt      <= '0;
            pready_q <= 1'b0;
          end else begin
            cnt      <= cnt + 4'd1;
            pready_q <= (cnt_inc == 5'(WAIT_STATES));
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  // Address decode, error classification and read mux
  always_comb begin
    ch      = apb.paddr[11:8];
    off     = apb.paddr[7:0];
    ch_ok   = (int'(ch) < NUM_CH);
    aligned = ((off & 8'(SB - 1)) == 8'h00);
    kidx    = (off - KEY_BASE) >> LSB_W;
    didx    = (off - DIN_BASE) >> LSB_W;
    oidx    = (off - DOUT_BASE) >> LSB_W;
    is_ctrl = (off == CTRL_OFF);
    is_stat = (off == STAT_OFF);
    is_key  = aligned && (off >= KEY_BASE)  && (off < KEY_BASE + BLK_SPAN);
    is_din  = aligned && (off >= DIN_BASE)  && (off < DIN_BASE + BLK_SPAN);
    is_dout = aligned && (off >= DOUT_BASE) && (off < DOUT_BASE + BLK_SPAN);
    mapped  = is_ctrl || is_stat || is_key || is_din || is_dout;

    busy_sel = 1'b0;
    rdata    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 4'(c)) begin
        busy_sel = busy_q[c];
        if (is_stat) rdata = {{(DW-2){1'b0}}, done_q[c], busy_q[c]};
`ifdef AES_APB_IRQ_EN
        if (is_ctrl) rdata = {{(DW-2){1'b0}}, irqen_q[c], 1'b0};
`endif
        for (int k = 0; k < W; k++) begin
          if (is_key  && kidx == 8'(k)) rdata = key_q[c][k];
          if (is_din  && didx == 8'(k)) rdata = din_q[c][k];
          if (is_dout && oidx == 8'(k)) rdata = dout_q[c][k];
        end
      end
    end

    start_req = is_ctrl && apb.pstrb[0] && apb.pwdata[0];
    // An all-zero strobe write is a silent no-op, so only address-level
    // faults can flag it; access-level faults need at least one lane.
    err = !ch_ok || !mapped ||
          (apb.pwrite && (|apb.pstrb) &&
           (is_dout || ((is_key || is_din || start_req) && busy_sel)));

    xfer   = (state == ACCESS) && pready_q && apb.psel && apb.penable;
    commit = xfer && apb.pwrite && !err;
  end

  assign apb.pready  = xfer;
  assign apb.pslverr = xfer && err;
  assign apb.prdata  = (xfer && !err && !apb.pwrite) ? rdata : '0;

  // Register file commit and core handshake
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < W; k++) begin
          key_q[c][k]  <= '0;
          din_q[c][k]  <= '0;
          dout_q[c][k] <= '0;
        end
      end
      busy_q  <= '0;
      done_q  <= '0;
      start_q <= '0;
`ifdef AES_APB_IRQ_EN
      irqen_q <= '0;
      irq_q   <= '0;
`endif
    end else begin
      start_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (core_done[c]) begin
          for (int k = 0; k < W; k++)
            dout_q[c][k] <= core_dout[c*BLOCK_WIDTH + k*DW +: DW];
          done_q[c] <= 1'b1;
          busy_q[c] <= 1'b0;
        end
        if (commit && ch == 4'(c)) begin
          for (int k = 0; k < W; k++) begin
            if (is_key && kidx == 8'(k))
              key_q[c][k] <= merge_bytes(key_q[c][k], apb.pwdata, apb.pstrb);
            if (is_din && didx == 8'(k))
              din_q[c][k] <= merge_bytes(din_q[c][k], apb.pwdata, apb.pstrb);
          end
          if (is_ctrl && apb.pstrb[0]) begin
            if (apb.pwdata[0]) begin
              start_q[c] <= 1'b1;
              busy_q[c]  <= 1'b1;
            end
`ifdef AES_APB_IRQ_EN
            irqen_q[c] <= apb.pwdata[1];
`endif
          end
          // A completion landing in the same cycle as the clear wins.
          if (is_stat && apb.pstrb[0] && apb.pwdata[1] && !core_done[c])
            done_q[c] <= 1'b0;
        end
      end
`ifdef AES_APB_IRQ_EN
      irq_q <= done_q & irqen_q;
`endif
    end
  end

  assign core_start = start_q;
`ifdef AES_APB_IRQ_EN
  assign irq = irq_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar k = 0; k < W; k++) begin : g_word
      assign core_key[c*BLOCK_WIDTH + k*DW +: DW] = key_q[c][k];
      assign core_din[c*BLOCK_WIDTH + k*DW +: DW] = din_q[c][k];
    end
  end
endmodule

// File: tb/tb_aes_apb_mc_slave.sv
module tb_aes_apb_mc_slave;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int SB  = 4;
  localparam int NCH = 2;
  localparam int BW  = 128;
  localparam int WS  = 1;
  localparam int NW  = BW / DW;

  logic pclk = 1'b0;
  logic preset;
  logic [NCH-1:0]    core_start, core_done;
  logic [NCH*BW-1:0] core_key, core_din, core_dout;
`ifdef AES_APB_IRQ_EN
  logic [NCH-1:0]    irq;
`endif

  always #5 pclk = ~pclk;

  aes_apb_mc_slave_if #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .APB_STROBE_WIDTH(SB)) apb();

  aes_apb_mc_slave #(
    .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .APB_STROBE_WIDTH(SB),
    .NUM_CH(NCH), .BLOCK_WIDTH(BW), .WAIT_STATES(WS)
  ) dut (
    .pclk(pclk), .preset(preset), .apb(apb),
    .core_start(core_start), .core_key(core_key), .core_din(core_din),
    .core_dout(core_dout), .core_done(core_done)
`ifdef AES_APB_IRQ_EN
    , .irq(irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: plain per-channel word arrays and flags
  logic [31:0] m_key  [NCH][NW];
  logic [31:0] m_din  [NCH][NW];
  logic [31:0] m_dout [NCH][NW];
  bit          m_busy [NCH];
  bit          m_done [NCH];
  bit          m_irqen[NCH];

  typedef struct {
    logic [31:0]    rdata;
    logic           err;
    logic [NCH-1:0] start;
    logic [11:0]    addr;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NW; k++) begin
        m_key[c][k] = 0; m_din[c][k] = 0; m_dout[c][k] = 0;
      end
      m_busy[c] = 0; m_done[c] = 0; m_irqen[c] = 0;
    end
  endfunction

  function automatic void model_done(input int c, input logic [127:0] v);
    for (int k = 0; k < NW; k++) m_dout[c][k] = v[32*k +: 32];
    m_done[c] = 1; m_busy[c] = 0;
  endfunction

  // region: 0 CTRL, 1 STATUS, 2 KEY, 3 DIN, 4 DOUT, -1 unmapped
  function automatic exp_t model_access(input logic [11:0] a, input logic [31:0] d,
                                        input bit wr, input logic [3:0] s);
    exp_t e;
    int c, off, rg, k;
    e.rdata = 0; e.err = 0; e.start = '0; e.addr = a;
    c = int'(a[11:8]); off = int'(a[7:0]); rg = -1; k = 0;
    if (off % 4 == 0) begin
      if (off == 0) rg = 0;
      else if (off == 4) rg = 1;
      else if (off >= 16 && off < 16 + 4*NW) begin rg = 2; k = (off - 16) / 4; end
      else if (off >= 48 && off < 48 + 4*NW) begin rg = 3; k = (off - 48) / 4; end
      else if (off >= 80 && off < 80 + 4*NW) begin rg = 4; k = (off - 80) / 4; end
    end
    if (c >= NCH || rg < 0) begin e.err = 1; return e; end
    if (!wr) begin
      case (rg)
`ifdef AES_APB_IRQ_EN
        0: e.rdata = m_irqen[c] ? 32'h2 : 32'h0;
`endif
        1: e.rdata = (m_done[c] ? 32'h2 : 32'h0) + (m_busy[c] ? 32'h1 : 32'h0);
        2: e.rdata = m_key[c][k];
        3: e.rdata = m_din[c][k];
        4: e.rdata = m_dout[c][k];
        default: e.rdata = 0;
      endcase
      return e;
    end
    if (s == 4'h0) return e;
    if (rg == 4 || ((rg == 2 || rg == 3) && m_busy[c]) ||
        (rg == 0 && s[0] && d[0] && m_busy[c])) begin
      e.err = 1; return e;
    end
    case (rg)
      0: if (s[0]) begin
           if (d[0]) begin m_busy[c] = 1; e.start[c] = 1'b1; end
`ifdef AES_APB_IRQ_EN
           m_irqen[c] = d[1];
`endif
         end
      1: if (s[0] && d[1]) m_done[c] = 0;
      2: for (int b = 0; b < 4; b++) if (s[b]) m_key[c][k][8*b +: 8] = d[8*b +: 8];
      3: for (int b = 0; b < 4; b++) if (s[b]) m_din[c][k][8*b +: 8] = d[8*b +: 8];
      default: ;
    endcase
    return e;
  endfunction

  // Monitor: pops the scoreboard on every completed transfer
  int             acc_cycles = 0;
  logic [NCH-1:0] exp_start_next = '0;
  always @(negedge pclk) begin
    exp_t e;
    if (preset) begin
      acc_cycles = 0;
      exp_start_next = '0;
    end else begin
      chk("core_start", core_start, exp_start_next);
      exp_start_next = '0;
      if (apb.psel && apb.penable && apb.pready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pready addr=%h", apb.paddr);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("prdata@%h", e.addr), apb.prdata, e.rdata);
          chk($sformatf("pslverr@%h", e.addr), apb.pslverr, e.err);
          chk("wait_states", acc_cycles, WS);
          exp_start_next = e.start;
        end
        acc_cycles = 0;
      end else begin
        if (apb.psel && apb.penable) acc_cycles++;
        else acc_cycles = 0;
        if (apb.prdata !== '0 || apb.pslverr !== 1'b0)
          chk("idle_outputs", {apb.pslverr, apb.prdata}, '0);
      end
    end
  end

  task automatic apb_xfer(input logic [11:0] a, input logic [31:0] d, input bit wr,
                          input logic [3:0] s, input int done_ch, input logic [127:0] done_val);
    exp_t e;
    int n;
    e = model_access(a, d, wr, s);
    sbq.push_back(e);
    @(posedge pclk); #1;
    apb.paddr = a; apb.pwdata = d; apb.pwrite = wr; apb.pstrb = s;
    apb.pprot = 3'($urandom); apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    n = 0;
    while (!apb.pready && n < 40) begin
      @(posedge pclk); #1;
      n++;
    end
    if (!apb.pready) begin
      checks++; errors++;
      $display("FAIL pready_timeout addr=%h", a);
      void'(sbq.pop_back());
    end else if (done_ch >= 0) begin
      core_done[done_ch] = 1'b1;
      core_dout[done_ch*BW +: BW] = done_val;
      model_done(done_ch, done_val);
    end
    @(posedge pclk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0; core_done = '0;
  endtask

  task automatic pulse_done(input int c, input logic [127:0] v);
    @(posedge pclk); #1;
    core_done[c] = 1'b1;
    core_dout[c*BW +: BW] = v;
    model_done(c, v);
    @(posedge pclk); #1;
    core_done = '0;
  endtask

  task automatic check_cores();
    logic [255:0] ek, ed;
    ek = '0; ed = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < NW; k++) begin
        ek[c*BW + k*32 +: 32] = m_key[c][k];
        ed[c*BW + k*32 +: 32] = m_din[c][k];
      end
    chk("core_key", core_key, ek);
    chk("core_din", core_din, ed);
  endtask

  logic [7:0] offs [12] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C,
                             8'h30, 8'h3C, 8'h50, 8'h58, 8'h0C, 8'h13};

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1);
  end

  initial begin
    apb.paddr = '0; apb.pwdata = '0; apb.pprot = '0; apb.psel = 1'b0;
    apb.penable = 1'b0; apb.pwrite = 1'b0; apb.pstrb = '0;
    core_done = '0; core_dout = '0;
    preset = 1'b1;
    model_reset();
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // Reset state
    chk("rst_pready", apb.pready, 1'b0);
    chk("rst_pslverr", apb.pslverr, 1'b0);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_core_start", core_start, '0);
    check_cores();
    apb_xfer(12'h004, 0, 0, 4'hF, -1, '0);

    // Ch1 key load and partial-strobe update
    for (int k = 0; k < NW; k++)
      apb_xfer(12'h110 + 12'(4*k), {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, 1, 4'hF, -1, '0);
    chk("key_ch1_full", core_key[BW +: BW], 128'h0C0D0E0F_08090A0B_04050607_00010203);
    apb_xfer(12'h110, 32'hFFFFFFFF, 1, 4'h2, -1, '0);
    chk("key_ch1_w0_strb", core_key[BW +: 32], 32'h0001FF03);
    apb_xfer(12'h110, 0, 0, 4'h0, -1, '0);
    check_cores();

    // Start ch0, busy protection, completion
    apb_xfer(12'h000, 32'h1, 1, 4'hF, -1, '0);
    apb_xfer(12'h004, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h030, 32'hDEADBEEF, 1, 4'hF, -1, '0);
    apb_xfer(12'h000, 32'h1, 1, 4'hF, -1, '0);
    check_cores();
    pulse_done(0, {4{32'hAAAAAAAA}});
    apb_xfer(12'h004, 0, 0, 4'hF, -1, '0);
    for (int k = 0; k < NW; k++) apb_xfer(12'h050 + 12'(4*k), 0, 0, 4'hF, -1, '0);

    // DONE clear racing a completion, then a plain clear
    apb_xfer(12'h004, 32'h2, 1, 4'hF, 0, {4{32'hBBBBBBBB}});
    apb_xfer(12'h004, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h004, 32'h2, 1, 4'hF, -1, '0);
    apb_xfer(12'h004, 0, 0, 4'hF, -1, '0);

    // Error accesses
    apb_xfer(12'h200, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h00C, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h050, 32'h12345678, 1, 4'hF, -1, '0);
    apb_xfer(12'h050, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h114, 32'h55555555, 1, 4'h0, -1, '0);
    check_cores();

`ifdef AES_APB_IRQ_EN
    apb_xfer(12'h100, 32'h2, 1, 4'hF, -1, '0);
    apb_xfer(12'h100, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h100, 32'h3, 1, 4'hF, -1, '0);
    pulse_done(1, {4{32'h01234567}});
    chk("irq_lag", irq, 2'b00);
    @(posedge pclk); #1;
    chk("irq_set", irq, 2'b10);
    apb_xfer(12'h104, 32'h2, 1, 4'hF, -1, '0);
    @(posedge pclk); #1;
    chk("irq_clear", irq, 2'b00);
`endif

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [11:0] a;
      if ($urandom_range(0, 4) == 0)
        pulse_done($urandom_range(0, NCH-1), {$urandom, $urandom, $urandom, $urandom});
      a = {4'($urandom_range(0, 2)), offs[$urandom_range(0, 11)]};
      apb_xfer(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), -1, '0);
      check_cores();
    end

    // Reset in the middle of a write: commit must be discarded
    @(posedge pclk); #1;
    apb.paddr = 12'h014; apb.pwdata = 32'hCAFEF00D; apb.pwrite = 1'b1; apb.pstrb = 4'hF;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    preset = 1'b1;
    @(posedge pclk); #1;
    chk("rst_mid_pready", apb.pready, 1'b0);
    preset = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0;
    model_reset();
    check_cores();
    apb_xfer(12'h014, 0, 0, 4'hF, -1, '0);
    apb_xfer(12'h104, 0, 0, 4'hF, -1, '0);

    repeat (4) @(posedge pclk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
